imem_i2c_loader: RTL and testbench

I2C target (responder) that receives a program image from an external I2C controller and writes it into instruction memory as 32-bit words. It is the write side of the instruction memory that the core's fetch path reads. While a load is in progress it holds the core in reset so fetch never observes a half-written image. Write-only: read requests are NACKed.

---
 rtl/imem_i2c_loader.sv | 206 ++++++++++++++++++++
 tb/tb_imem_i2c_loader.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_i2c_loader.sv
// imem_i2c_loader
//   Write-only I2C target that streams a program image into instruction memory
//   as little-endian 32-bit words. It holds the core in reset while a load is
//   in progress, so fetch never sees a half-written image. Read requests are
//   not acknowledged.
//
// Ports
//   clk        system clock (>= 8x SCL)
//   rst        asynchronous active-high reset
//   scl_i      raw SCL pin level
//   sda_i      raw SDA pin level
//   sda_oe     1 = pull SDA low (open drain)
//   mem_we     one-cycle instruction-memory write strobe
//   mem_addr   byte address of the write ({0, word_index, 2'b00})
//   mem_wdata  write data word
//   core_hold  hold request ORed into the core reset
//   load_done  one-cycle pulse at STOP when the transaction wrote a word
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus free or not addressed; waiting for START
// RX_ADDR   | shifting in the address/RW byte
// ACK_ADDR  | driving the ACK for our write address
// RX_DATA   | shifting in pointer bytes (first two) or data bytes
// ACK_DATA  | driving the ACK for a received byte
// WAIT_STOP | not addressed to us (or read); ignore bits until STOP/START

module imem_i2c_loader #(
  parameter logic [6:0] DEV_ADDR = 7'h2A,
  parameter int         WORD_AW  = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_oe,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_hold,
  output logic        load_done
);

  typedef enum logic [2:0] {
    IDLE, RX_ADDR, ACK_ADDR, RX_DATA, ACK_DATA, WAIT_STOP
  } state_t;

  state_t state;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;

  logic [2:0]         bit_cnt;
  logic [6:0]         shreg;
  logic [1:0]         byte_cnt;    // 0: ptr high, 1: ptr low, 2: data bytes
  logic [1:0]         data_cnt;    // byte position within the current word
  logic [7:0]         ptr_hi;
  logic [23:0]        acc;         // lower three bytes of the word being built
  logic [WORD_AW-1:0] word_index;
  logic [WORD_AW-1:0] mem_idx;
  logic               wrote;

  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [7:0] rx_byte;

  // Idle bus level is high, so the synchronizers reset to 1 to avoid a
  // spurious edge right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_s1 <= 1'b1;
      scl_s2 <= 1'b1;
      scl_d  <= 1'b1;
      sda_s1 <= 1'b1;
      sda_s2 <= 1'b1;
      sda_d  <= 1'b1;
    end else begin
      scl_s1 <= scl_i;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_i;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise  =  scl_s2 & ~scl_d;
  assign scl_fall  = ~scl_s2 &  scl_d;
  // Bus conditions require SCL stable high across the SDA transition.
  assign start_det =  scl_s2 &  scl_d & ~sda_s2 &  sda_d;
  assign stop_det  =  scl_s2 &  scl_d &  sda_s2 & ~sda_d;

  // The byte completes on the 8th rising edge, before sda_s2 is shifted in.
  assign rx_byte = {shreg, sda_s2};

  assign mem_addr = {{(30-WORD_AW){1'b0}}, mem_idx, 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      byte_cnt   <= '0;
      data_cnt   <= '0;
      ptr_hi     <= '0;
      acc        <= '0;
      word_index <= '0;
      mem_idx    <= '0;
      wrote      <= 1'b0;
      sda_oe     <= 1'b0;
      mem_we     <= 1'b0;
      mem_wdata  <= '0;
      core_hold  <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      mem_we    <= 1'b0;
      load_done <= 1'b0;

      if (stop_det) begin
        state     <= IDLE;
        sda_oe    <= 1'b0;
        core_hold <= 1'b0;
        load_done <= wrote;
        wrote     <= 1'b0;
      end else if (start_det) begin
        // Also covers repeated START: pointer must be re-sent, partial word dropped.
        state    <= RX_ADDR;
        bit_cnt  <= '0;
        byte_cnt <= '0;
        data_cnt <= '0;
        acc      <= '0;
        wrote    <= 1'b0;
        sda_oe   <= 1'b0;
      end else begin
        case (state)
          IDLE, WAIT_STOP: ;

          RX_ADDR: begin
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                if (rx_byte[7:1] == DEV_ADDR && !rx_byte[0]) begin
                  state     <= ACK_ADDR;
                  core_hold <= 1'b1;
                end else begin
                  state <= WAIT_STOP;
                end
              end
            end
          end

          // First falling edge after the 8th bit starts the ACK, the next ends it.
          ACK_ADDR, ACK_DATA: begin
            if (scl_fall) begin
              if (!sda_oe) begin
                sda_oe <= 1'b1;
              end else begin
                sda_oe <= 1'b0;
                state  <= RX_DATA;
              end
            end
          end

          RX_DATA: begin
            if (scl_rise) begin
              shreg   <= {shreg[5:0], sda_s2};
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                state <= ACK_DATA;
                case (byte_cnt)
                  2'd0: begin
                    ptr_hi   <= rx_byte;
                    byte_cnt <= 2'd1;
                  end
                  2'd1: begin
                    // Upper pointer bits beyond the image space are dropped.
                    word_index <= WORD_AW'({ptr_hi, rx_byte});
                    byte_cnt   <= 2'd2;
                  end
                  default: begin
                    data_cnt <= data_cnt + 2'd1;
                    case (data_cnt)
                      2'd0: acc[7:0]   <= rx_byte;
                      2'd1: acc[15:8]  <= rx_byte;
                      2'd2: acc[23:16] <= rx_byte;
                      default: begin
                        mem_we     <= 1'b1;
                        mem_idx    <= word_index;
                        mem_wdata  <= {rx_byte, acc};
                        word_index <= word_index + WORD_AW'(1);
                        wrote      <= 1'b1;
                      end
                    endcase
                  end
                endcase
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_i2c_loader.sv
// Directed bench for imem_i2c_loader: a bit-banged I2C controller drives the
// open-drain bus, a monitor records every write and pulse, and results are
// compared with hand-computed values.
module tb_imem_i2c_loader;

  localparam int Q = 5;  // quarter SCL period in clk cycles (SCL = clk/20)

  logic        clk = 1'b0;
  logic        rst;
  logic        scl_tb, sda_tb;
  logic        scl_i, sda_i;
  logic        sda_oe, mem_we, core_hold, load_done;
  logic [31:0] mem_addr, mem_wdata;

  int n_vec = 0;
  int n_err = 0;

  int          we_cnt, done_cnt, oe_cnt, hold_cnt;
  logic [31:0] wq_addr[$];
  logic [31:0] wq_data[$];
  logic        ack;

  imem_i2c_loader dut (
    .clk       (clk),
    .rst       (rst),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .sda_oe    (sda_oe),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .core_hold (core_hold),
    .load_done (load_done)
  );

  always #5 clk = ~clk;

  // Open-drain bus: either side can pull low.
  assign scl_i = scl_tb;
  assign sda_i = sda_tb & ~sda_oe;

  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt++;
      wq_addr.push_back(mem_addr);
      wq_data.push_back(mem_wdata);
    end
    if (load_done) done_cnt++;
    if (sda_oe)    oe_cnt++;
    if (core_hold) hold_cnt++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic clr_mon();
    we_cnt = 0; done_cnt = 0; oe_cnt = 0; hold_cnt = 0;
    wq_addr.delete();
    wq_data.delete();
  endtask

  task automatic i2c_start();
    sda_tb = 1'b1; wait_clk(Q);
    scl_tb = 1'b1; wait_clk(Q);
    sda_tb = 1'b0; wait_clk(Q);
    scl_tb = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_tb = 1'b0; wait_clk(Q);
    scl_tb = 1'b1; wait_clk(Q);
    sda_tb = 1'b1; wait_clk(4*Q);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      sda_tb = b[i]; wait_clk(Q);
      scl_tb = 1'b1; wait_clk(2*Q);
      scl_tb = 1'b0; wait_clk(Q);
    end
  endtask

  task automatic ack_clock(output logic a);
    sda_tb = 1'b1; wait_clk(Q);
    scl_tb = 1'b1; wait_clk(Q);
    @(negedge clk);
    a = ~sda_i;
    wait_clk(Q);
    scl_tb = 1'b0; wait_clk(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    send_bits(b);
    ack_clock(a);
  endtask

  task automatic send_acked(input string tag, input logic [7:0] b);
    logic a;
    send_byte(b, a);
    chk(tag, {31'd0, a}, 32'd1);
  endtask

  initial begin
    scl_tb = 1'b1;
    sda_tb = 1'b1;
    rst    = 1'b1;
    clr_mon();
    wait_clk(4);
    @(negedge clk);
    chk("rst_sda_oe",    {31'd0, sda_oe},    32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},    32'd0);
    chk("rst_core_hold", {31'd0, core_hold}, 32'd0);
    chk("rst_load_done", {31'd0, load_done}, 32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_mem_wdata", mem_wdata,          32'd0);
    rst = 1'b0;
    wait_clk(10);

    // Single word at address 0
    clr_mon();
    i2c_start();
    send_acked("t1_ack_addr", 8'h54);
    @(negedge clk);
    chk("t1_hold_after_ack", {31'd0, core_hold}, 32'd1);
    send_acked("t1_ack_ptrh", 8'h00);
    send_acked("t1_ack_ptrl", 8'h00);
    send_acked("t1_ack_d0", 8'h13);
    send_acked("t1_ack_d1", 8'h05);
    send_acked("t1_ack_d2", 8'h00);
    send_acked("t1_ack_d3", 8'h00);
    chk("t1_hold_before_stop", {31'd0, core_hold}, 32'd1);
    i2c_stop();
    chk("t1_we_cnt", we_cnt, 1);
    chk("t1_addr", wq_addr[0], 32'h0000_0000);
    chk("t1_wdata", wq_data[0], 32'h0000_0513);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_hold_after_stop", {31'd0, core_hold}, 32'd0);

    // Pointer at top of image space wraps to 0
    clr_mon();
    i2c_start();
    send_acked("t2_ack_addr", 8'h54);
    send_acked("t2_ack_ptrh", 8'h03);
    send_acked("t2_ack_ptrl", 8'hFF);
    for (int i = 1; i <= 8; i++) send_acked("t2_ack_data", 8'(i));
    i2c_stop();
    chk("t2_we_cnt", we_cnt, 2);
    chk("t2_addr0", wq_addr[0], 32'h0000_0FFC);
    chk("t2_wdata0", wq_data[0], 32'h0403_0201);
    chk("t2_addr1", wq_addr[1], 32'h0000_0000);
    chk("t2_wdata1", wq_data[1], 32'h0807_0605);
    chk("t2_done_cnt", done_cnt, 1);

    // Wrong address, then read request: never acknowledged
    clr_mon();
    i2c_start();
    send_byte(8'h56, ack);
    chk("t3_nack_56", {31'd0, ack}, 32'd0);
    send_byte(8'h00, ack);
    send_byte(8'h12, ack);
    i2c_stop();
    i2c_start();
    send_byte(8'h55, ack);
    chk("t3_nack_55", {31'd0, ack}, 32'd0);
    send_byte(8'h00, ack);
    i2c_stop();
    chk("t3_oe_cnt", oe_cnt, 0);
    chk("t3_we_cnt", we_cnt, 0);
    chk("t3_done_cnt", done_cnt, 0);
    chk("t3_hold_cnt", hold_cnt, 0);

    // Trailing partial word discarded
    clr_mon();
    i2c_start();
    send_acked("t4_ack_addr", 8'h54);
    send_acked("t4_ack_ptrh", 8'h00);
    send_acked("t4_ack_ptrl", 8'h10);
    for (int i = 0; i < 6; i++) send_acked("t4_ack_data", 8'h11 + 8'(i));
    i2c_stop();
    chk("t4_we_cnt", we_cnt, 1);
    chk("t4_addr", wq_addr[0], 32'h0000_0040);
    chk("t4_wdata", wq_data[0], 32'h1413_1211);
    chk("t4_done_cnt", done_cnt, 1);

    // Repeated START drops partial word and requires a new pointer
    clr_mon();
    i2c_start();
    send_acked("t5_ack_addr", 8'h54);
    send_acked("t5_ack_ptrh", 8'h00);
    send_acked("t5_ack_ptrl", 8'h02);
    send_acked("t5_ack_p0", 8'h77);
    send_acked("t5_ack_p1", 8'h66);
    i2c_start();
    send_acked("t5_ack_addr2", 8'h54);
    send_acked("t5_ack_ptrh2", 8'h00);
    send_acked("t5_ack_ptrl2", 8'h08);
    send_acked("t5_ack_d0", 8'hAA);
    send_acked("t5_ack_d1", 8'hBB);
    send_acked("t5_ack_d2", 8'hCC);
    send_acked("t5_ack_d3", 8'hDD);
    i2c_stop();
    chk("t5_we_cnt", we_cnt, 1);
    chk("t5_addr", wq_addr[0], 32'h0000_0020);
    chk("t5_wdata", wq_data[0], 32'hDDCC_BBAA);
    chk("t5_done_cnt", done_cnt, 1);

    // Reset while driving ACK
    clr_mon();
    i2c_start();
    send_bits(8'h54);
    wait_clk(2);
    @(negedge clk);
    chk("t6_oe_before_rst", {31'd0, sda_oe}, 32'd1);
    chk("t6_hold_before_rst", {31'd0, core_hold}, 32'd1);
    rst = 1'b1;
    #1;
    chk("t6_oe_in_rst", {31'd0, sda_oe}, 32'd0);
    chk("t6_hold_in_rst", {31'd0, core_hold}, 32'd0);
    chk("t6_we_in_rst", {31'd0, mem_we}, 32'd0);
    wait_clk(3);
    @(negedge clk);
    rst = 1'b0;
    clr_mon();
    ack_clock(ack);
    chk("t6_no_ack_after_rst", {31'd0, ack}, 32'd0);
    send_byte(8'h00, ack);
    send_byte(8'h00, ack);
    for (int i = 0; i < 4; i++) send_byte(8'h54, ack);
    i2c_stop();
    chk("t6_oe_cnt", oe_cnt, 0);
    chk("t6_we_cnt", we_cnt, 0);
    chk("t6_done_cnt", done_cnt, 0);
    chk("t6_hold_cnt", hold_cnt, 0);
    i2c_start();
    send_acked("t6_ack_recover", 8'h54);
    i2c_stop();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
